// File: rtl/mem_req_responder_pkg.sv
// Shared opcode map and burst-width helper for the internal memory request protocol.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// The opcode values must match the ones driven by the per-request control FSMs.
package mem_req_responder_pkg;

  typedef enum logic [1:0] {
    MEM_OPCODE_READ         = 2'd0,
    MEM_OPCODE_WRITE_ADDR   = 2'd1,
    ACCEL_OPCODE_WRITE_DATA = 2'd2,
    MEM_OPCODE_RSVD         = 2'd3
  } mem_opcode_e;

  // Burst length in beats for a width encoding: beats = 1 << width.
  function automatic logic [31:0] beats_from_width(input logic [7:0] width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/mem_burst_counter.sv
// Burst address/beat counter shared by the read and write paths of mem_req_responder.
// Latency: load and step take effect on the next clk edge; last is combinational.
// Backpressure: none; the owner only pulses step on an accepted beat.
// Ports: load/load_addr/load_beats_left start a burst, step advances one beat,
//        cur_addr/beats_left give the current position, last flags the final beat.
module mem_burst_counter #(
  parameter int ADDR_W = 10,
  parameter int BL_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [BL_W-1:0]   load_beats_left,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [BL_W-1:0]   beats_left,
  output logic              last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else if (load) begin
      cur_addr   <= load_addr;
      beats_left <= load_beats_left;
    end else if (step) begin
      // Address wraps naturally modulo 2^ADDR_W.
      cur_addr <= cur_addr + 1'b1;
      if (beats_left != '0) beats_left <= beats_left - 1'b1;
    end
  end

  assign last = (beats_left == '0);

endmodule

// File: rtl/mem_req_responder.sv
// Memory-side endpoint: serves read bursts and locked write-address/write-data pairs on a 1-port SRAM.
// Latency: read beat 3 cycles after acceptance (1 beat / 3 cycles); ack one cycle after the last beat.
// Backpressure: rd_valid/rd_data hold until rd_ready; write beats only taken on wr_valid; req_ready only in IDLE.
// Ports: req_* request in, ack/ack_source_id completion, err rejected request, rd_* read stream out,
//        wr_* write stream in, sram_* single-port SRAM (sram_rdata one cycle after a read enable).
module mem_req_responder
  import mem_req_responder_pkg::*;
#(
  parameter int ADDR_W            = 10,
  parameter int DATA_W            = 32,
  parameter int OPCODE_W          = 2,
  parameter int ADDR_W_ENCODING_W = 3,
  parameter int SRC_ID_W          = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [ADDR_W_ENCODING_W-1:0] req_width,
  input  logic [OPCODE_W-1:0]          req_opcode,
  input  logic [SRC_ID_W-1:0]          req_source_id,
  output logic                         mem_ready,
  output logic                         ack,
  output logic [SRC_ID_W-1:0]          ack_source_id,
  output logic                         err,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_last,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         sram_en,
  output logic                         sram_we,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_wdata,
  input  logic [DATA_W-1:0]            sram_rdata
);

  localparam int BL_W = (1 << ADDR_W_ENCODING_W) - 1;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_OUT, WR_BEAT, ACK} state_t;

  state_t                       state_q, state_d;
  logic                         lock_q;
  logic [ADDR_W-1:0]            wa_addr_q;
  logic [ADDR_W_ENCODING_W-1:0] wa_width_q;
  logic [SRC_ID_W-1:0]          lock_src_q;
  logic [SRC_ID_W-1:0]          src_q;
  logic                         err_q, err_d;
  logic [DATA_W-1:0]            rd_data_q;
  logic                         lock_set, lock_clr;

  logic                         cnt_load, cnt_step, cnt_last;
  logic [ADDR_W-1:0]            cnt_load_addr, cur_addr;
  logic [BL_W-1:0]              cnt_load_bl, beats_left;

  logic rd_fire, wr_fire;

  assign rd_fire  = (state_q == RD_OUT) && rd_ready;
  assign wr_fire  = (state_q == WR_BEAT) && wr_valid;
  assign cnt_step = rd_fire || wr_fire;

  mem_burst_counter #(.ADDR_W(ADDR_W), .BL_W(BL_W)) u_cnt (
    .clk             (clk),
    .rst_n           (rst_n),
    .load            (cnt_load),
    .load_addr       (cnt_load_addr),
    .load_beats_left (cnt_load_bl),
    .step            (cnt_step),
    .cur_addr        (cur_addr),
    .beats_left      (beats_left),
    .last            (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    err_d         = 1'b0;
    lock_set      = 1'b0;
    lock_clr      = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_addr = req_addr;
    cnt_load_bl   = BL_W'(beats_from_width(8'(req_width)) - 32'd1);
    case (state_q)
      IDLE: begin
        // req_ready is high in IDLE, so req_valid alone is a handshake.
        if (req_valid) begin
          case (mem_opcode_e'(req_opcode))
            MEM_OPCODE_READ: begin
              // A held write lock blocks reads even though req_ready is high.
              if (lock_q) err_d = 1'b1;
              else begin
                cnt_load = 1'b1;
                state_d  = RD_ISSUE;
              end
            end
            MEM_OPCODE_WRITE_ADDR: begin
              if (lock_q) err_d = 1'b1;
              else begin
                lock_set = 1'b1;
                state_d  = ACK;
              end
            end
            ACCEL_OPCODE_WRITE_DATA: begin
              if (!lock_q || (req_source_id != lock_src_q)) err_d = 1'b1;
              else begin
                cnt_load      = 1'b1;
                cnt_load_addr = wa_addr_q;
                cnt_load_bl   = BL_W'(beats_from_width(8'(wa_width_q)) - 32'd1);
                state_d       = WR_BEAT;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = RD_OUT;
      RD_OUT:   if (rd_ready) state_d = cnt_last ? ACK : RD_ISSUE;
      WR_BEAT: begin
        if (wr_valid && cnt_last) begin
          lock_clr = 1'b1;
          state_d  = ACK;
        end
      end
      ACK:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      wa_addr_q  <= '0;
      wa_width_q <= '0;
      lock_src_q <= '0;
      src_q      <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (lock_set) begin
        lock_q     <= 1'b1;
        wa_addr_q  <= req_addr;
        wa_width_q <= req_width;
        lock_src_q <= req_source_id;
      end else if (lock_clr) begin
        lock_q <= 1'b0;
      end
      if ((state_q == IDLE) && req_valid) src_q <= req_source_id;
      if (state_q == RD_WAIT) rd_data_q <= sram_rdata;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_ready     = !lock_q;
  assign ack           = (state_q == ACK);
  assign ack_source_id = src_q;
  assign err           = err_q;
  assign rd_valid      = (state_q == RD_OUT);
  assign rd_data       = rd_data_q;
  assign rd_last       = rd_valid && cnt_last;
  assign wr_ready      = (state_q == WR_BEAT);
  assign sram_en       = (state_q == RD_ISSUE) || wr_fire;
  assign sram_we       = wr_fire;
  assign sram_addr     = sram_en ? cur_addr : '0;
  assign sram_wdata    = wr_fire ? wr_data : '0;

endmodule

// File: tb/tb_mem_req_responder.sv
module tb_mem_req_responder;
  import mem_req_responder_pkg::*;

  localparam int AW = 10, DW = 32, OW = 2, EW = 3, SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [EW-1:0] req_width;
  logic [OW-1:0] req_opcode;
  logic [SW-1:0] req_source_id;
  logic          mem_ready, ack, err;
  logic [SW-1:0] ack_source_id;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  mem_req_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_width(req_width), .req_opcode(req_opcode), .req_source_id(req_source_id),
    .mem_ready(mem_ready), .ack(ack), .ack_source_id(ack_source_id), .err(err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM (the bench's memory) and the reference copy of what it should hold.
  logic [DW-1:0] sram    [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (sram_en && !sram_we) sram_rdata <= sram[sram_addr];
    if (sram_en && sram_we)  sram[sram_addr] <= sram_wdata;
  end

  // Event counters sampled mid-cycle.
  int n_rd_en = 0, n_wr_en = 0, n_ack = 0, n_err = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_en && !sram_we) n_rd_en++;
      if (sram_en && sram_we)  n_wr_en++;
      if (ack) n_ack++;
      if (err) n_err++;
    end
  end

  // Reference model of the lock.
  logic          m_lock;
  logic [SW-1:0] m_lock_src;
  logic [AW-1:0] m_wa_addr;
  logic [EW-1:0] m_wa_width;

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, req_ready, 1);
    check({tag, " mem_ready"}, mem_ready, 1);
    check({tag, " ack"}, ack, 0);
    check({tag, " ack_src"}, ack_source_id, 0);
    check({tag, " err"}, err, 0);
    check({tag, " rd_valid"}, rd_valid, 0);
    check({tag, " rd_data"}, rd_data, 0);
    check({tag, " rd_last"}, rd_last, 0);
    check({tag, " wr_ready"}, wr_ready, 0);
    check({tag, " sram_en"}, sram_en, 0);
    check({tag, " sram_we"}, sram_we, 0);
    check({tag, " sram_addr"}, sram_addr, 0);
    check({tag, " sram_wdata"}, sram_wdata, 0);
  endtask

  // Called just after a posedge; returns just after the handshake edge.
  task automatic send_req(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [EW-1:0] w, input logic [SW-1:0] src);
    req_valid = 1'b1; req_opcode = op; req_addr = addr; req_width = w; req_source_id = src;
    @(negedge clk);
    check("req_ready at request", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_reject(input string tag);
    int acc0, a0;
    acc0 = n_rd_en + n_wr_en;
    a0 = n_ack;
    @(negedge clk);
    check({tag, " err"}, err, 1);
    check({tag, " ack"}, ack, 0);
    @(negedge clk);
    check({tag, " err one cycle"}, err, 0);
    tick();
    check({tag, " no sram access"}, n_rd_en + n_wr_en, acc0);
    check({tag, " no ack"}, n_ack, a0);
    check({tag, " mem_ready"}, mem_ready, !m_lock);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [EW-1:0] w,
                         input logic [SW-1:0] src, input int stall_beat, input int stall_len);
    int nb, e0, a0, budget;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    nb = 1 << w;
    e0 = n_rd_en;
    a0 = n_ack;
    send_req(2'(MEM_OPCODE_READ), addr, w, src);
    for (int i = 0; i < nb; i++) begin
      a = addr + AW'(i);
      exp_d = ref_mem[a];
      budget = 0;
      @(negedge clk);
      while (!rd_valid && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      check("rd_valid arrives", rd_valid, 1);
      check("rd_data", rd_data, exp_d);
      check("rd_last", rd_last, (i == nb - 1));
      if (i == stall_beat) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          check("rd_valid held in stall", rd_valid, 1);
          check("rd_data stable in stall", rd_data, exp_d);
          check("no sram_en in stall", sram_en, 0);
        end
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
    @(negedge clk);
    check("read ack", ack, 1);
    check("read ack_src", ack_source_id, src);
    tick();
    check("read single ack", n_ack - a0, 1);
    check("read sram_en count", n_rd_en - e0, nb);
  endtask

  task automatic do_write_addr(input logic [AW-1:0] addr, input logic [EW-1:0] w,
                               input logic [SW-1:0] src);
    send_req(2'(MEM_OPCODE_WRITE_ADDR), addr, w, src);
    @(negedge clk);
    check("wa ack", ack, 1);
    check("wa ack_src", ack_source_id, src);
    m_lock = 1'b1; m_lock_src = src; m_wa_addr = addr; m_wa_width = w;
    tick();
    check("wa mem_ready low", mem_ready, 0);
  endtask

  task automatic do_write_data(input logic [SW-1:0] src);
    int nb, gap;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    nb = 1 << m_wa_width;
    send_req(2'(ACCEL_OPCODE_WRITE_DATA), '0, '0, src);
    for (int i = 0; i < nb; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("wr idle no sram_en", sram_en, 0);
        tick();
      end
      a = m_wa_addr + AW'(i);
      d = $urandom;
      wr_valid = 1'b1; wr_data = d;
      @(negedge clk);
      check("wr_ready", wr_ready, 1);
      check("wr sram_en", sram_en, 1);
      check("wr sram_we", sram_we, 1);
      check("wr sram_addr", sram_addr, a);
      check("wr sram_wdata", sram_wdata, d);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      ref_mem[a] = d;
    end
    @(negedge clk);
    check("wd ack", ack, 1);
    check("wd ack_src", ack_source_id, src);
    m_lock = 1'b0;
    tick();
    check("wd mem_ready high", mem_ready, 1);
    for (int i = 0; i < nb; i++) begin
      a = m_wa_addr + AW'(i);
      check("sram contents", sram[a], ref_mem[a]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int a0, budget;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_width = '0; req_opcode = '0;
    req_source_id = '0; rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    m_lock = 1'b0; m_lock_src = '0; m_wa_addr = '0; m_wa_width = '0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    tick(); tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Two-beat read across the top of the address space.
    sram[10'h3FE] = 32'hAAAA_0001; ref_mem[10'h3FE] = 32'hAAAA_0001;
    sram[10'h3FF] = 32'hBBBB_0002; ref_mem[10'h3FF] = 32'hBBBB_0002;
    do_read(10'h3FE, 3'd1, 4'd5, -1, 0);

    // Four-beat read with a 4-cycle stall on the third beat.
    do_read(10'h100, 3'd2, 4'd9, 2, 4);

    // Locked write with address wrap, and rejected requests while locked.
    do_write_addr(10'h3FF, 3'd1, 4'd3);
    send_req(2'(MEM_OPCODE_READ), 10'h010, 3'd0, 4'd7);
    expect_reject("read while locked");
    send_req(2'(ACCEL_OPCODE_WRITE_DATA), 10'h000, 3'd0, 4'd7);
    expect_reject("wd wrong src");
    send_req(2'(MEM_OPCODE_WRITE_ADDR), 10'h020, 3'd0, 4'd7);
    expect_reject("wa while locked");
    do_write_data(4'd3);

    // Write data without a lock, and the reserved opcode.
    send_req(2'(ACCEL_OPCODE_WRITE_DATA), 10'h000, 3'd0, 4'd3);
    expect_reject("wd no lock");
    send_req(2'd3, 10'h055, 3'd1, 4'd2);
    expect_reject("reserved opcode");
    @(negedge clk);
    check("idle after errors", req_ready, 1);
    tick();

    // Reset during the first beat of a four-beat read.
    a0 = n_ack;
    send_req(2'(MEM_OPCODE_READ), 10'h200, 3'd2, 4'd6);
    budget = 0;
    @(negedge clk);
    while (!rd_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("rd_valid before reset", rd_valid, 1);
    rst_n = 1'b0;
    m_lock = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-burst reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("no ack after reset", n_ack, a0);
    do_read(10'h200, 3'd0, 4'd6, -1, 0);

    // Randomized mix checked against the reference memory and lock model.
    for (int it = 0; it < 30; it++) begin
      logic [AW-1:0] ra;
      logic [EW-1:0] rw;
      logic [SW-1:0] rs;
      ra = AW'($urandom);
      rw = EW'($urandom_range(0, 3));
      rs = SW'($urandom);
      case ($urandom_range(0, 3))
        0: do_read(ra, rw, rs, $urandom_range(0, (1 << rw) - 1), $urandom_range(0, 3));
        1: begin
          do_write_addr(ra, EW'($urandom_range(0, 2)), rs);
          send_req(2'(MEM_OPCODE_READ), ra, 3'd0, rs + 4'd1);
          expect_reject("rand read while locked");
          do_write_data(rs);
        end
        2: begin
          send_req(2'(ACCEL_OPCODE_WRITE_DATA), ra, rw, rs);
          expect_reject("rand wd no lock");
        end
        default: begin
          send_req(2'd3, ra, rw, rs);
          expect_reject("rand reserved");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_req_responder.md
Name: mem_req_responder

Overview:
- Memory-side endpoint of the internal request protocol that the per-request control FSMs issue through the NoC arbiter.
- Accepts MEM_OPCODE_READ, MEM_OPCODE_WRITE_ADDR and ACCEL_OPCODE_WRITE_DATA requests and runs the matching beat sequence on a single-port SRAM interface.
- Streams read data out, or consumes write data in.
- Returns a one-cycle ack tagged with the requester's source_id, and drives mem_ready to show the memory resource is free.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, beat data width.
- OPCODE_W, 2, internal opcode width.
- ADDR_W_ENCODING_W, 3, width-encoding field width; beats = 1 << width.
- SRC_ID_W, 4, source_id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request from arbiter.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_addr  in  ADDR_W  start address.
- req_width  in  ADDR_W_ENCODING_W  burst length encoding.
- req_opcode  in  OPCODE_W  operation.
- req_source_id  in  SRC_ID_W  requester tag.
- mem_ready  out  1  memory free; no write lock held.
- ack  out  1  one-cycle completion pulse.
- ack_source_id  out  SRC_ID_W  tag for ack.
- err  out  1  one-cycle pulse for a dropped or illegal request.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  read beat consumer ready.
- rd_data  out  DATA_W  read beat.
- rd_last  out  1  final beat of the burst.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DATA_W  write beat.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid exactly 1 cycle after sram_en & !sram_we.

Behaviour:
- Clock is clk. Reset is rst_n, synchronous, active-low.
- Reset values:
  - state = IDLE, lock = 0.
  - All outputs 0, except mem_ready = 1 and req_ready = 1.
  - Reset mid-burst abandons the burst; no ack is sent.
- States: IDLE, RD_ISSUE, RD_WAIT, RD_OUT, WR_BEAT, ACK.
- req_ready = (state == IDLE). mem_ready = !lock.
- Request capture in IDLE on a handshake: latch addr into cur_addr, beats_left = (1 << width) - 1, latch source_id.
- IDLE, READ:
  - If lock is set, or the opcode is reserved (3): pulse err next cycle and stay in IDLE.
  - Otherwise go to RD_ISSUE.
- RD_ISSUE: sram_en = 1, sram_we = 0, sram_addr = cur_addr; go to RD_WAIT.
- RD_WAIT: capture sram_rdata into rd_data, assert rd_valid, go to RD_OUT.
- RD_OUT: hold rd_valid and rd_data until rd_ready.
  - rd_last = (beats_left == 0).
  - On handshake: if last, go to ACK; else cur_addr + 1 (wraps modulo 2^ADDR_W), decrement beats_left, go to RD_ISSUE.
  - Throughput is 1 beat per 3 cycles.
- IDLE, WRITE_ADDR:
  - If lock is set, pulse err.
  - Otherwise set lock and latch wa_addr, wa_width and lock_src; go to ACK.
- IDLE, WRITE_DATA:
  - If !lock, or source_id != lock_src, pulse err.
  - Otherwise load cur_addr = wa_addr and beats_left from wa_width, then go to WR_BEAT.
- WR_BEAT: wr_ready = 1.
  - On wr_valid: sram_en = sram_we = 1 combinationally the same cycle, with sram_addr = cur_addr and sram_wdata = wr_data.
  - Then cur_addr + 1. If beats_left == 0: clear lock and go to ACK; else decrement.
- ACK: ack = 1 for exactly one cycle, ack_source_id = latched source; next state is IDLE.
- Error pulse: err is a 1-cycle registered pulse; ack is not asserted for errored requests.
- lock has priority: while lock is set, only WRITE_DATA from lock_src is served. READ is rejected even though req_ready = 1, because mem_ready = 0 already tells requesters not to send.
- sram_en is never asserted outside RD_ISSUE, or WR_BEAT with wr_valid.

Decomposition:
- Shared package (common.sv / opcode_map.svh), with the same values used by the control FSMs:
  - MEM_OPCODE_READ = 0
  - MEM_OPCODE_WRITE_ADDR = 1
  - ACCEL_OPCODE_WRITE_DATA = 2
  - 3 reserved
  - Width-encoding helper function beats_from_width().
- state_t enum is local to the module.
- One natural sub-module: mem_burst_counter, which holds cur_addr and beats_left, handles load, step and last detect, and is reused by the read and write paths.

Test Plan:
- READ addr=0x3FE, width=1, src=5, SRAM preloaded A,B at 0x3FE,0x3FF → rd beats A then B (rd_last on B), then ack=1 with ack_source_id=5 one cycle after the B handshake.
- READ width=2 with rd_ready held low 4 cycles on beat 2 → rd_data stable while stalled, no extra sram_en, 4 beats total, single ack.
- WRITE_ADDR addr=0x3FF, width=1, src=3 → ack src=3, mem_ready=0. Then WRITE_DATA src=3 with beats X,Y → SRAM 0x3FF=X, 0x000=Y (wrap), ack src=3, mem_ready=1.
- While locked by src=3: READ src=7 and WRITE_DATA src=7 → err pulses, no ack, no SRAM access, lock held.
- WRITE_DATA with no lock, and an opcode=3 request → err pulse each, state returns to IDLE.
- Reset asserted mid-read on beat 1 of 4 → next cycle all outputs at reset values, mem_ready=1, no ack ever for that request.
